// File: rtl/ram_288_line_packer_pkg.sv
// Shared parameters, types and state encoding for the 288-bit x 64-line buffer packer.
// Imported by line_packer_shift and ram_288_line_packer.
package line_packer_pkg;

  localparam int ELEM_W = 16;
  localparam int LANES  = 18;
  localparam int DATA_W = ELEM_W * LANES;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int LANE_W = $clog2(LANES);

  typedef logic [ELEM_W-1:0] elem_t;
  typedef logic [DATA_W-1:0] line_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   count_t;
  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // True when the element in this lane completes a line.
  function automatic logic is_last_lane(input lane_t lane);
    return lane == lane_t'(LANES - 1);
  endfunction

endpackage

// File: rtl/ram_288_line_packer_shift.sv
// Lane register bank: decodes the write lane, clears on request and presents the merged
// line (bank plus the incoming element). Zero-fill exists only with LINE_PACKER_FLUSH_EN.
module line_packer_shift
  import line_packer_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [LANE_W-1:0] wr_lane,
  input  logic [ELEM_W-1:0] wr_data,
`ifdef LINE_PACKER_FLUSH_EN
  input  logic              zero_fill,
`endif
  output logic [DATA_W-1:0] line_out
);

  line_t shadow;

  // NOTE: the bank is cleared with reset so its contents are deterministic afterwards;
  // it is a plain register bank, not a RAM, so this costs no special macro support.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      shadow <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_lane == lane_t'(i)) shadow[i*ELEM_W +: ELEM_W] <= wr_data;
      end
    end
  end

  // NOTE: line_out takes a full default before the loop, so no path leaves it unassigned.
  always_comb begin
    line_out = shadow;
    for (int i = 0; i < LANES; i++) begin
      if (wr_en && (wr_lane == lane_t'(i))) begin
        line_out[i*ELEM_W +: ELEM_W] = wr_data;
      end
`ifdef LINE_PACKER_FLUSH_EN
      else if (zero_fill && (lane_t'(i) > wr_lane)) begin
        line_out[i*ELEM_W +: ELEM_W] = '0;
      end
`endif
    end
  end

endmodule

// File: rtl/ram_288_line_packer.sv
// Packs LANES elements per 288-bit line, writes lines to the buffer with a wrapping pointer
// and holds off the producer after each frame until frame_ack. Option: LINE_PACKER_FLUSH_EN.
module ram_288_line_packer
  import line_packer_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_last,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              wen,
  output logic              frame_done,
  input  logic              frame_ack,
  output logic [ADDR_W:0]   lines_written
);

  state_t state;
  lane_t  lane_idx;
  addr_t  line_ptr;
  line_t  line_next;
  logic   accept;
  logic   line_end;
  logic   frame_end;

  assign accept = in_valid && in_ready;

`ifdef LINE_PACKER_FLUSH_EN
  // in_last closes both the current line and the frame, whatever lane it lands in.
  assign line_end  = accept && (is_last_lane(lane_idx) || in_last);
  assign frame_end = line_end && ((line_ptr == addr_t'(DEPTH - 1)) || in_last);
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign line_end  = accept && is_last_lane(lane_idx);
  assign frame_end = line_end && (line_ptr == addr_t'(DEPTH - 1));
`endif

  line_packer_shift u_shift (
    .clk      (clk),
    .clear    (!resetn),
    .wr_en    (accept),
    .wr_lane  (lane_idx),
    .wr_data  (in_data),
`ifdef LINE_PACKER_FLUSH_EN
    .zero_fill(in_last),
`endif
    .line_out (line_next)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= FILL;
      in_ready      <= 1'b0;
      wen           <= 1'b0;
      waddr         <= '0;
      wdata         <= '0;
      frame_done    <= 1'b0;
      lines_written <= '0;
      lane_idx      <= '0;
      line_ptr      <= '0;
    end else begin
      wen <= 1'b0;
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (accept) lane_idx <= line_end ? '0 : lane_idx + lane_t'(1);
          if (line_end) begin
            wen           <= 1'b1;
            waddr         <= line_ptr;
            wdata         <= line_next;
            lines_written <= lines_written + count_t'(1);
            // Every frame, short or full, starts again at line 0.
            line_ptr      <= frame_end ? '0 : line_ptr + addr_t'(1);
            if (frame_end) begin
              state      <= FULL;
              in_ready   <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        FULL: begin
          if (frame_ack) begin
            state         <= FILL;
            in_ready      <= 1'b1;
            frame_done    <= 1'b0;
            lines_written <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_288_line_packer.sv
// Self-checking bench for ram_288_line_packer: random stimulus against a queue-based
// reference model of the packing and frame rules.
module tb_ram_288_line_packer;

  localparam int EW    = 16;
  localparam int NL    = 18;
  localparam int DEPTH = 64;
`ifdef LINE_PACKER_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic          clk;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] in_data;
  logic          in_last;
  logic [5:0]    waddr;
  logic [287:0]  wdata;
  logic          wen;
  logic          frame_done;
  logic          frame_ack;
  logic [6:0]    lines_written;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [EW-1:0] m_cur[$];
  bit            m_ready = 1'b0;
  bit            m_wen   = 1'b0;
  bit            m_done  = 1'b0;
  bit            m_full  = 1'b0;
  int            m_lines = 0;
  int            m_line_no = 0;
  logic [5:0]    m_waddr = '0;
  logic [287:0]  m_wdata = '0;

  ram_288_line_packer dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .waddr        (waddr),
    .wdata        (wdata),
    .wen          (wen),
    .frame_done   (frame_done),
    .frame_ack    (frame_ack),
    .lines_written(lines_written)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive one cycle of inputs, advance past the edge and update the model.
  task automatic step(input bit v, input logic [EW-1:0] d, input bit l, input bit a, input bit rn);
    bit acc;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    frame_ack = a;
    resetn    = rn;
    acc = v && m_ready;
    @(posedge clk);
    #1;
    m_wen = 1'b0;
    if (!rn) begin
      m_cur.delete();
      m_full = 0; m_done = 0; m_lines = 0; m_line_no = 0;
      m_waddr = '0; m_wdata = '0; m_ready = 0;
    end else if (m_full) begin
      if (a) begin
        m_full = 0; m_done = 0; m_lines = 0;
      end
      m_ready = !m_full;
    end else begin
      if (acc) begin
        m_cur.push_back(d);
        if (m_cur.size() == NL || (FLUSH && l)) begin
          m_wdata = '0;
          foreach (m_cur[i]) m_wdata[i*EW +: EW] = m_cur[i];
          m_cur.delete();
          m_wen = 1'b1;
          m_waddr = 6'(m_line_no);
          m_lines++;
          m_line_no = (m_line_no + 1) % DEPTH;
          if (m_lines == DEPTH || (FLUSH && l)) begin
            m_full = 1; m_done = 1; m_line_no = 0;
          end
        end
      end
      m_ready = !m_full;
    end
  endtask

  task automatic do_reset();
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 16'(i + 7), 0, 0, 0);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready c%0d: got %b want 0", i, in_ready); end
      n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL reset_wen c%0d: got %b want 0", i, wen); end
      n_cmp++; if (waddr !== 6'd0) begin n_bad++; $display("FAIL reset_waddr c%0d: got %0d want 0", i, waddr); end
      n_cmp++; if (wdata !== 288'd0) begin n_bad++; $display("FAIL reset_wdata c%0d: got %h want 0", i, wdata); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done c%0d: got %b want 0", i, frame_done); end
      n_cmp++; if (lines_written !== 7'd0) begin n_bad++; $display("FAIL reset_lines c%0d: got %0d want 0", i, lines_written); end
    end
    step(0, '0, 0, 0, 1);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_pack();
    for (int i = 1; i <= NL; i++) begin
      step(1, 16'(i), 0, 0, 1);
      n_cmp++; if (wen !== m_wen) begin n_bad++; $display("FAIL pack_wen e%0d: got %b want %b", i, wen, m_wen); end
    end
    n_cmp++; if (wen !== 1'b1) begin n_bad++; $display("FAIL pack_line_wen: got %b want 1", wen); end
    n_cmp++; if (waddr !== 6'd0) begin n_bad++; $display("FAIL pack_waddr: got %0d want 0", waddr); end
    n_cmp++; if (wdata[15:0] !== 16'h0001) begin n_bad++; $display("FAIL pack_lane0: got %h want 0001", wdata[15:0]); end
    n_cmp++; if (wdata[287:272] !== 16'h0012) begin n_bad++; $display("FAIL pack_lane17: got %h want 0012", wdata[287:272]); end
    n_cmp++; if (wdata !== m_wdata) begin n_bad++; $display("FAIL pack_wdata: got %h want %h", wdata, m_wdata); end
    step(0, '0, 0, 0, 1);
    n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL pack_wen_pulse: got %b want 0", wen); end
    n_cmp++; if (wdata !== m_wdata || waddr !== 6'd0) begin n_bad++; $display("FAIL pack_hold: got %0d/%h want 0/%h", waddr, wdata, m_wdata); end
  endtask

  task automatic test_full_frame();
    int pulses = 0;
    do_reset();
    for (int c = 0; c < 2000 && !m_full; c++) begin
      step(1, 16'($urandom), 0, 0, 1);
      n_cmp++; if (wen !== m_wen) begin n_bad++; $display("FAIL full_wen c%0d: got %b want %b", c, wen, m_wen); end
      if (wen === 1'b1) begin
        n_cmp++; if (waddr !== 6'(pulses)) begin n_bad++; $display("FAIL full_waddr: got %0d want %0d", waddr, pulses); end
        n_cmp++; if (wdata !== m_wdata) begin n_bad++; $display("FAIL full_wdata line %0d: got %h want %h", pulses, wdata, m_wdata); end
        pulses++;
      end
    end
    n_cmp++; if (pulses != DEPTH) begin n_bad++; $display("FAIL full_pulses: got %0d want %0d", pulses, DEPTH); end
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL full_frame_done: got %b want 1", frame_done); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (lines_written !== 7'd64) begin n_bad++; $display("FAIL full_lines: got %0d want 64", lines_written); end
    for (int c = 0; c < 20; c++) begin
      step(1, 16'($urandom), 0, 0, 1);
      n_cmp++; if (wen !== 1'b0) begin n_bad++; $display("FAIL stall_wen c%0d: got %b want 0", c, wen); end
      n_cmp++; if (in_ready !== 1'b0 || frame_done !== 1'b1) begin n_bad++; $display("FAIL stall_flags c%0d: got ready %b done %b want 0 1", c, in_ready, frame_done); end
      n_cmp++; if (lines_written !== 7'd64) begin n_bad++; $display("FAIL stall_lines c%0d: got %0d want 64", c, lines_written); end
    end
  endtask

  task automatic test_ack();
    step(0, '0, 0, 1, 1);
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL ack_frame_done: got %b want 0", frame_done); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ack_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (lines_written !== 7'd0) begin n_bad++; $display("FAIL ack_lines: got %0d want 0", lines_written); end
    for (int c = 0; c < 6; c++) begin
      step(0, '0, 0, 1, 1);
      n_cmp++; if (in_ready !== 1'b1 || frame_done !== 1'b0 || wen !== 1'b0) begin
        n_bad++; $display("FAIL ack_in_fill c%0d: got ready %b done %b wen %b want 1 0 0", c, in_ready, frame_done, wen);
      end
    end
  endtask

  // Runs straight after a full frame, so the lane bank holds stale data above lane 4.
  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      step(1, 16'($urandom), (i == 4), 0, 1);
      n_cmp++; if (wen !== m_wen) begin n_bad++; $display("FAIL flush_wen e%0d: got %b want %b", i, wen, m_wen); end
    end
    n_cmp++; if (wdata !== m_wdata) begin n_bad++; $display("FAIL flush_wdata: got %h want %h", wdata, m_wdata); end
    n_cmp++; if (waddr !== m_waddr) begin n_bad++; $display("FAIL flush_waddr: got %0d want %0d", waddr, m_waddr); end
    n_cmp++; if (frame_done !== FLUSH) begin n_bad++; $display("FAIL flush_frame_done: got %b want %b", frame_done, FLUSH); end
    n_cmp++; if (lines_written !== 7'(FLUSH)) begin n_bad++; $display("FAIL flush_lines: got %0d want %0d", lines_written, FLUSH); end
    n_cmp++; if (in_ready !== !FLUSH) begin n_bad++; $display("FAIL flush_in_ready: got %b want %b", in_ready, !FLUSH); end
    step(0, '0, 0, 1, 1);
    n_cmp++; if (in_ready !== 1'b1 || frame_done !== 1'b0 || lines_written !== 7'd0) begin
      n_bad++; $display("FAIL flush_ack: got ready %b done %b lines %0d want 1 0 0", in_ready, frame_done, lines_written);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 16'($urandom), 0, 0, 1);
    step(1, 16'($urandom), 0, 0, 0);
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < NL; i++) begin
      step(1, 16'($urandom), 0, 0, 1);
      n_cmp++; if (wen !== m_wen) begin n_bad++; $display("FAIL midrst_wen e%0d: got %b want %b", i, wen, m_wen); end
    end
    n_cmp++; if (wen !== 1'b1 || waddr !== 6'd0) begin n_bad++; $display("FAIL midrst_line: got wen %b addr %0d want 1 0", wen, waddr); end
    n_cmp++; if (wdata !== m_wdata) begin n_bad++; $display("FAIL midrst_wdata: got %h want %h", wdata, m_wdata); end
  endtask

  task automatic test_random();
    bit v, l, a;
    for (int c = 0; c < 4000; c++) begin
      v = ($urandom_range(9) < 7);
      l = ($urandom_range(39) == 0);
      a = m_full ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0);
      step(v, 16'($urandom), l, a, 1);
      n_cmp++; if (in_ready !== m_ready) begin n_bad++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, m_ready); end
      n_cmp++; if (wen !== m_wen) begin n_bad++; $display("FAIL rnd_wen c%0d: got %b want %b", c, wen, m_wen); end
      n_cmp++; if (waddr !== m_waddr) begin n_bad++; $display("FAIL rnd_waddr c%0d: got %0d want %0d", c, waddr, m_waddr); end
      n_cmp++; if (wdata !== m_wdata) begin n_bad++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, wdata, m_wdata); end
      n_cmp++; if (frame_done !== m_done) begin n_bad++; $display("FAIL rnd_frame_done c%0d: got %b want %b", c, frame_done, m_done); end
      n_cmp++; if (lines_written !== 7'(m_lines)) begin n_bad++; $display("FAIL rnd_lines c%0d: got %0d want %0d", c, lines_written, m_lines); end
    end
  endtask

  initial begin
    clk       = 1'b0;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    frame_ack = 1'b0;
    test_reset();
    test_pack();
    test_full_frame();
    test_ack();
    test_flush();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
